// File: rtl/mine_neighbour_counter_pkg.sv
// Shared types, constants and neighbour offset tables for the mine neighbour counter.
package mine_neighbour_counter_pkg;

   typedef logic [3:0] cell_t;

   localparam cell_t MINE_CODE = 4'd15;
   localparam int    NUM_SLOTS = 9;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      DRAIN,
      WRITE
   } state_e;

   // Slot 0 is the cell itself; slots 1..8 walk the neighbours row by row.
   localparam logic signed [1:0] DX_TBL [NUM_SLOTS] =
      '{2'sd0, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
   localparam logic signed [1:0] DY_TBL [NUM_SLOTS] =
      '{2'sd0, -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};

endpackage

// File: rtl/mine_neighbour_counter_addr_gen.sv
// Combinational neighbour address generator: coordinate + offset slot k -> address and in-range flag.
module neighbour_addr_gen
   import mine_neighbour_counter_pkg::*;
#(
   parameter int COORD_W = 6
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] dim,
   input  logic [3:0]         k,
   output logic [COORD_W-1:0] addr_x,
   output logic [COORD_W-1:0] addr_y,
   output logic               in_range
);

   logic signed [1:0] dx;
   logic signed [1:0] dy;
   logic              ok_x;
   logic              ok_y;
   logic              k_ok;

   always_comb begin
      dx   = 2'sd0;
      dy   = 2'sd0;
      k_ok = (k < 4'(NUM_SLOTS));
      if (k_ok) begin
         dx = DX_TBL[k];
         dy = DY_TBL[k];
      end
   end

   // Edge tests on the unmodified coordinate, so the address never wraps into range.
   assign ok_x = (dx == -2'sd1) ? (x != '0) : (dx == 2'sd1) ? (x != dim) : 1'b1;
   assign ok_y = (dy == -2'sd1) ? (y != '0) : (dy == 2'sd1) ? (y != dim) : 1'b1;

   assign addr_x   = x + {{(COORD_W-2){dx[1]}}, dx};
   assign addr_y   = y + {{(COORD_W-2){dy[1]}}, dy};
   assign in_range = k_ok && ok_x && ok_y;

endmodule

// File: rtl/mine_neighbour_counter.sv
// Counts mines around each scanned cell and writes the 4-bit cell value to board-state memory.
// Optional macro MINE_NEIGHBOUR_TOTAL_EN adds the mine_total output (saturating mined-cell count).
module mine_neighbour_counter
   import mine_neighbour_counter_pkg::*;
#(
   parameter int               COORD_W   = 6,
   parameter int               CNT_W     = 4,
   parameter logic [CNT_W-1:0] MINE_CODE = mine_neighbour_counter_pkg::MINE_CODE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         dimension_size,
   input  logic               coord_valid,
   output logic               coord_ready,
   input  logic [COORD_W-1:0] x_in,
   input  logic [COORD_W-1:0] y_in,
   output logic               mine_rd_en,
   output logic [COORD_W-1:0] mine_rd_x,
   output logic [COORD_W-1:0] mine_rd_y,
   input  logic               mine_bit,
   output logic               cnt_wr_en,
   output logic [COORD_W-1:0] cnt_wr_x,
   output logic [COORD_W-1:0] cnt_wr_y,
   output logic [CNT_W-1:0]   cnt_wr_val,
   output logic               coord_err,
   output logic               board_done
`ifdef MINE_NEIGHBOUR_TOTAL_EN
   ,
   output logic [9:0]         mine_total
`endif
);

   state_e state_q;
   state_e state_d;

   logic [3:0]         k_q;
   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] y_q;
   logic [COORD_W-1:0] dim_q;
   logic               self_mine_q;
   cell_t              count_q;
   logic               vld_p1;
   logic               self_p1;
   logic               coord_err_q;
   logic               board_done_q;

   logic [COORD_W-1:0] dim_in;
   logic               accept;
   logic               range_bad;
   logic               origin_in;
   logic               last_cell;
   logic [COORD_W-1:0] gen_x;
   logic [COORD_W-1:0] gen_y;
   logic               gen_ok;

   assign dim_in    = COORD_W'(dimension_size);
   assign accept    = coord_valid && coord_ready;
   assign range_bad = (x_in > dim_in) || (y_in > dim_in);
   assign origin_in = (x_in == '0) && (y_in == '0);
   assign last_cell = (x_q == dim_q) && (y_q == dim_q);

   neighbour_addr_gen #(
      .COORD_W (COORD_W)
   ) u_addr_gen (
      .x        (x_q),
      .y        (y_q),
      .dim      (dim_q),
      .k        (k_q),
      .addr_x   (gen_x),
      .addr_y   (gen_y),
      .in_range (gen_ok)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept && !range_bad) state_d = READ;
         READ:    if (k_q == 4'(NUM_SLOTS - 1)) state_d = DRAIN;
         DRAIN:   state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The error pulse cycle keeps the block busy so the next accept is two cycles after a bad one.
   always_comb begin
      coord_ready = (state_q == IDLE) && (dimension_size != 5'd0) && !coord_err_q;
      mine_rd_en  = 1'b0;
      mine_rd_x   = '0;
      mine_rd_y   = '0;
      cnt_wr_en   = 1'b0;
      cnt_wr_x    = '0;
      cnt_wr_y    = '0;
      cnt_wr_val  = '0;
      if (state_q == READ) begin
         mine_rd_en = gen_ok;
         mine_rd_x  = gen_x;
         mine_rd_y  = gen_y;
      end
      if (state_q == WRITE) begin
         cnt_wr_en  = 1'b1;
         cnt_wr_x   = x_q;
         cnt_wr_y   = y_q;
         cnt_wr_val = self_mine_q ? MINE_CODE : CNT_W'(count_q);
      end
   end

   assign coord_err  = coord_err_q;
   assign board_done = board_done_q;

   // Control state: FSM, slot index, read-valid pipe, status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         k_q          <= '0;
         vld_p1       <= 1'b0;
         coord_err_q  <= 1'b0;
         board_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vld_p1      <= mine_rd_en;
         coord_err_q <= accept && range_bad;
         k_q         <= (state_q == READ) ? k_q + 4'd1 : 4'd0;
         if (accept && origin_in)
            board_done_q <= 1'b0;
         else if ((state_q == WRITE) && last_cell)
            board_done_q <= 1'b1;
      end
   end

   // Datapath: latched cell and accumulator; read data lands one cycle after its strobe.
   always_ff @(posedge clk) begin
      self_p1 <= (k_q == 4'd0);
      if (accept) begin
         x_q         <= x_in;
         y_q         <= y_in;
         dim_q       <= dim_in;
         self_mine_q <= 1'b0;
         count_q     <= '0;
      end else if (vld_p1) begin
         if (self_p1)
            self_mine_q <= mine_bit;
         else if (mine_bit)
            count_q <= count_q + cell_t'(1);
      end
   end

`ifdef MINE_NEIGHBOUR_TOTAL_EN
   always_ff @(posedge clk) begin
      if (rst)
         mine_total <= '0;
      else if (accept && origin_in)
         mine_total <= '0;
      else if ((state_q == WRITE) && self_mine_q && (mine_total != 10'd1023))
         mine_total <= mine_total + 10'd1;
   end
`endif

endmodule

// File: tb/tb_mine_neighbour_counter.sv
// Directed bench for mine_neighbour_counter with a mine-bitmap memory model.
module tb_mine_neighbour_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] dimension_size;
   logic       coord_valid;
   logic       coord_ready;
   logic [5:0] x_in;
   logic [5:0] y_in;
   logic       mine_rd_en;
   logic [5:0] mine_rd_x;
   logic [5:0] mine_rd_y;
   logic       mine_bit;
   logic       cnt_wr_en;
   logic [5:0] cnt_wr_x;
   logic [5:0] cnt_wr_y;
   logic [3:0] cnt_wr_val;
   logic       coord_err;
   logic       board_done;

   int n_checks = 0;
   int n_errors = 0;

   bit mines [0:63][0:63];

   // Results gathered by run_cell over cycles E0+1..E0+14.
   int        rd_n, rd_first, rd_last, bad_rd;
   int        wr_n, wr_cyc, err_n, err_cyc, ready_cyc;
   logic [3:0] wr_val;
   logic [5:0] wr_x, wr_y;
   logic [14:0] done_vec;
   logic       ready_at_accept;

   always #5 clk = ~clk;

   // Read data is only meaningful after a strobe; drive 1 otherwise to expose missing masking.
   always @(posedge clk) mine_bit <= mine_rd_en ? mines[mine_rd_x][mine_rd_y] : 1'b1;

   mine_neighbour_counter dut (
      .clk            (clk),
      .rst            (rst),
      .dimension_size (dimension_size),
      .coord_valid    (coord_valid),
      .coord_ready    (coord_ready),
      .x_in           (x_in),
      .y_in           (y_in),
      .mine_rd_en     (mine_rd_en),
      .mine_rd_x      (mine_rd_x),
      .mine_rd_y      (mine_rd_y),
      .mine_bit       (mine_bit),
      .cnt_wr_en      (cnt_wr_en),
      .cnt_wr_x       (cnt_wr_x),
      .cnt_wr_y       (cnt_wr_y),
      .cnt_wr_val     (cnt_wr_val),
      .coord_err      (coord_err),
      .board_done     (board_done)
   );

   task automatic clear_mines();
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 64; j++)
            mines[i][j] = 1'b0;
   endtask

   // Called at a negedge; accepts (cx,cy) on the next posedge and observes 14 cycles.
   task automatic run_cell(input logic [5:0] cx, input logic [5:0] cy, input logic [4:0] dim_mid);
      int ref_dim;
      ref_dim = int'(dimension_size);
      rd_n = 0; rd_first = -1; rd_last = -1; bad_rd = 0;
      wr_n = 0; wr_cyc = -1; err_n = 0; err_cyc = -1; ready_cyc = -1;
      wr_val = '0; wr_x = '0; wr_y = '0; done_vec = '0;
      ready_at_accept = coord_ready;
      x_in = cx; y_in = cy; coord_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      coord_valid = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         if (mine_rd_en) begin
            rd_n++;
            if (rd_first < 0) rd_first = c;
            rd_last = c;
            if (int'(mine_rd_x) > ref_dim || int'(mine_rd_y) > ref_dim) bad_rd++;
         end
         if (cnt_wr_en) begin
            wr_n++; wr_cyc = c; wr_val = cnt_wr_val; wr_x = cnt_wr_x; wr_y = cnt_wr_y;
         end
         if (coord_err) begin
            err_n++; err_cyc = c;
         end
         if (coord_ready && ready_cyc < 0) ready_cyc = c;
         done_vec[c] = board_done;
         if (c == 3 && dim_mid != 5'd0) dimension_size = dim_mid;
         if (c < 14) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; coord_valid = 1'b0; x_in = '0; y_in = '0; dimension_size = 5'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (coord_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", coord_ready); end
      n_checks++;
      if ({mine_rd_en, cnt_wr_en, coord_err, board_done} !== 4'b0000) begin
         n_errors++; $display("FAIL reset_strobes: got %b want 0000", {mine_rd_en, cnt_wr_en, coord_err, board_done});
      end
      n_checks++;
      if ({mine_rd_x, mine_rd_y, cnt_wr_x, cnt_wr_y, cnt_wr_val} !== 28'd0) begin
         n_errors++; $display("FAIL reset_values: got %h want 0", {mine_rd_x, mine_rd_y, cnt_wr_x, cnt_wr_y, cnt_wr_val});
      end
   endtask

   task automatic test_top_edge();
      clear_mines(); mines[1][1] = 1'b1; mines[2][1] = 1'b1;
      dimension_size = 5'd3;
      run_cell(6'd1, 6'd0, 5'd0);
      n_checks++;
      if (ready_at_accept !== 1'b1) begin n_errors++; $display("FAIL edge_ready_in: got %b want 1", ready_at_accept); end
      n_checks++;
      if (rd_n != 6) begin n_errors++; $display("FAIL edge_reads: got %0d want 6", rd_n); end
      n_checks++;
      if (rd_first != 1 || rd_last != 9) begin n_errors++; $display("FAIL edge_read_window: got %0d..%0d want 1..9", rd_first, rd_last); end
      n_checks++;
      if (bad_rd != 0) begin n_errors++; $display("FAIL edge_read_range: got %0d want 0", bad_rd); end
      n_checks++;
      if (wr_n != 1 || wr_cyc != 11) begin n_errors++; $display("FAIL edge_write_cycle: got n=%0d at %0d want n=1 at 11", wr_n, wr_cyc); end
      n_checks++;
      if (wr_val !== 4'd2) begin n_errors++; $display("FAIL edge_val: got %0d want 2", wr_val); end
      n_checks++;
      if (wr_x !== 6'd1 || wr_y !== 6'd0) begin n_errors++; $display("FAIL edge_addr: got (%0d,%0d) want (1,0)", wr_x, wr_y); end
      n_checks++;
      if (ready_cyc != 12) begin n_errors++; $display("FAIL edge_ready_back: got %0d want 12", ready_cyc); end
   endtask

   task automatic test_corner_mine();
      clear_mines(); mines[0][0] = 1'b1;
      dimension_size = 5'd3;
      run_cell(6'd0, 6'd0, 5'd0);
      n_checks++;
      if (rd_n != 4) begin n_errors++; $display("FAIL corner_reads: got %0d want 4", rd_n); end
      n_checks++;
      if (bad_rd != 0) begin n_errors++; $display("FAIL corner_read_range: got %0d want 0", bad_rd); end
      n_checks++;
      if (wr_n != 1 || wr_val !== 4'd15) begin n_errors++; $display("FAIL corner_val: got n=%0d val=%0d want n=1 val=15", wr_n, wr_val); end
      n_checks++;
      if (done_vec !== 15'd0) begin n_errors++; $display("FAIL corner_done: got %b want 0", done_vec); end
   endtask

   task automatic test_full_count();
      clear_mines();
      for (int i = 0; i <= 2; i++)
         for (int j = 0; j <= 2; j++)
            mines[i][j] = 1'b1;
      mines[1][1] = 1'b0;
      dimension_size = 5'd2;
      run_cell(6'd1, 6'd1, 5'd0);
      n_checks++;
      if (rd_n != 9) begin n_errors++; $display("FAIL full_reads: got %0d want 9", rd_n); end
      n_checks++;
      if (wr_n != 1 || wr_val !== 4'd8) begin n_errors++; $display("FAIL full_val: got n=%0d val=%0d want n=1 val=8", wr_n, wr_val); end
   endtask

   task automatic test_board_done();
      clear_mines();
      dimension_size = 5'd3;
      // dimension_size drops to 1 mid-cell; the latched 3 must still govern this cell.
      run_cell(6'd3, 6'd3, 5'd1);
      n_checks++;
      if (rd_n != 4 || bad_rd != 0) begin n_errors++; $display("FAIL last_reads: got %0d (bad %0d) want 4 (bad 0)", rd_n, bad_rd); end
      n_checks++;
      if (wr_n != 1 || wr_val !== 4'd0) begin n_errors++; $display("FAIL last_val: got n=%0d val=%0d want n=1 val=0", wr_n, wr_val); end
      n_checks++;
      if (done_vec[11] !== 1'b0 || done_vec[12] !== 1'b1 || done_vec[14] !== 1'b1) begin
         n_errors++; $display("FAIL done_rise: got c11=%b c12=%b c14=%b want 0 1 1", done_vec[11], done_vec[12], done_vec[14]);
      end
      dimension_size = 5'd3;
      run_cell(6'd0, 6'd0, 5'd0);
      n_checks++;
      if (done_vec[1] !== 1'b0) begin n_errors++; $display("FAIL done_clear: got %b want 0", done_vec[1]); end
   endtask

   task automatic test_coord_err();
      clear_mines();
      dimension_size = 5'd3;
      run_cell(6'd5, 6'd2, 5'd0);
      n_checks++;
      if (err_n != 1 || err_cyc != 1) begin n_errors++; $display("FAIL err_pulse: got n=%0d at %0d want n=1 at 1", err_n, err_cyc); end
      n_checks++;
      if (rd_n != 0 || wr_n != 0) begin n_errors++; $display("FAIL err_no_access: got rd=%0d wr=%0d want 0 0", rd_n, wr_n); end
      n_checks++;
      if (ready_cyc != 2) begin n_errors++; $display("FAIL err_ready_back: got %0d want 2", ready_cyc); end
   endtask

   task automatic test_zero_dim();
      int rd_seen;
      rd_seen = 0;
      dimension_size = 5'd0;
      @(negedge clk);
      n_checks++;
      if (coord_ready !== 1'b0) begin n_errors++; $display("FAIL zero_dim_ready: got %b want 0", coord_ready); end
      coord_valid = 1'b1; x_in = 6'd0; y_in = 6'd0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (mine_rd_en || cnt_wr_en || coord_err) rd_seen++;
      end
      coord_valid = 1'b0;
      n_checks++;
      if (rd_seen != 0) begin n_errors++; $display("FAIL zero_dim_ignored: got %0d active cycles want 0", rd_seen); end
      dimension_size = 5'd3;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int wr_seen;
      clear_mines(); mines[0][0] = 1'b1; mines[2][2] = 1'b1;
      dimension_size = 5'd3;
      x_in = 6'd1; y_in = 6'd1; coord_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      coord_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({coord_ready, mine_rd_en, cnt_wr_en, coord_err, board_done} !== 5'b10000) begin
         n_errors++; $display("FAIL mid_reset_outputs: got %b want 10000", {coord_ready, mine_rd_en, cnt_wr_en, coord_err, board_done});
      end
      wr_seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (cnt_wr_en || mine_rd_en) wr_seen++;
         @(negedge clk);
      end
      n_checks++;
      if (wr_seen != 0) begin n_errors++; $display("FAIL mid_reset_no_write: got %0d active cycles want 0", wr_seen); end
      run_cell(6'd1, 6'd1, 5'd0);
      n_checks++;
      if (rd_n != 9 || wr_n != 1 || wr_cyc != 11 || wr_val !== 4'd2) begin
         n_errors++; $display("FAIL mid_reset_fresh: got rd=%0d wr=%0d at %0d val=%0d want 9 1 11 2", rd_n, wr_n, wr_cyc, wr_val);
      end
   endtask

   initial begin
      clear_mines();
      test_reset();
      test_top_edge();
      test_corner_mine();
      test_full_count();
      test_board_done();
      test_coord_err();
      test_zero_dim();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mine_neighbour_counter.md
Name: mine_neighbour_counter

Overview:
- Board-initialisation stage directly downstream of the board coordinate scanner.
- For each accepted cell (x, y), reads the cell and its 8 neighbours from the mine bitmap.
- Writes one 4-bit cell value into the board-state memory: 0..8 is the neighbour mine count; 15 means the cell itself is a mine.
- Flags completion when the last cell (dim, dim) has been written.

Parameters:
- COORD_W, 6, coordinate width; matches the scanner's x/y outputs.
- CNT_W, 4, cell value width.
- MINE_CODE, 4'd15, value written for a mined cell.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dimension_size  in  5  board edge index; valid coords are 0..dimension_size inclusive
- coord_valid  in  1  upstream cell coordinate valid
- coord_ready  out  1  block can accept a coordinate
- x_in, y_in  in  COORD_W each  cell coordinate
- mine_rd_en  out  1  mine bitmap read strobe
- mine_rd_x, mine_rd_y  out  COORD_W each  read address
- mine_bit  in  1  read data, valid the cycle after mine_rd_en
- cnt_wr_en  out  1  single-cycle write strobe
- cnt_wr_x, cnt_wr_y  out  COORD_W each  write address
- cnt_wr_val  out  CNT_W  cell value
- coord_err  out  1  single-cycle pulse: an out-of-range coordinate was accepted
- board_done  out  1  level; set when (dim, dim) is written

Behaviour:
- Reset: state IDLE.
  - Outputs after reset: coord_ready=1; mine_rd_en=0; cnt_wr_en=0; coord_err=0; board_done=0; all address and value outputs 0.
  - Reset mid-cell aborts with no write.
- Sampling: dimension_size is sampled at accept and held for the cell.
- FSM states: IDLE, READ, DRAIN, WRITE.
- IDLE:
  - coord_ready=1 only when dimension_size != 0.
  - Accept when coord_valid && coord_ready (edge E0); latch x, y, dim.
  - If x > dim or y > dim: pulse coord_err in cycle E0+1, return to IDLE, no reads, no write.
  - Otherwise go to READ.
- READ, 9 cycles (E0+1..E0+9), offset index k=0..8:
  - Offset order: (0,0), (-1,-1), (0,-1), (+1,-1), (-1,0), (+1,0), (-1,+1), (0,+1), (+1,+1).
  - Address = latched coordinate + offset.
  - mine_rd_en=1 only if the address is in 0..dim on both axes. Test x==0 / y==0 for -1 and x==dim / y==dim for +1; never wrap.
  - Out-of-range offsets: mine_rd_en=0 and a delayed valid bit masks the slot.
- Accumulation:
  - A valid bit follows mine_rd_en by 1 cycle. On each valid cycle, k=0 data sets self_mine; k=1..8 data increments a 4-bit neighbour count (max 8, no overflow).
  - DRAIN (E0+10) accumulates the last slot.
- WRITE (E0+11):
  - cnt_wr_en=1 for exactly one cycle; cnt_wr_x/y = latched coordinate.
  - cnt_wr_val = MINE_CODE if self_mine, else the neighbour count.
  - If x==dim && y==dim, board_done is set from E0+12.
  - Next state IDLE; coord_ready high again at E0+12. Throughput is 1 cell per 12 cycles.
- board_done: cleared on rst, or on acceptance of coordinate (0,0).
- coord_ready low: coord_valid is ignored, and upstream must hold x_in/y_in.
- dimension_size changes mid-cell: no effect until the next accept.

Optional Feature:
- Macro: MINE_NEIGHBOUR_TOTAL_EN.
- When defined:
  - Adds output port mine_total (10 bits), the count of cells written with MINE_CODE.
  - Cleared on rst and on acceptance of (0,0).
  - Increments in the WRITE cycle and saturates at 1023.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared game package:
  - typedef for the 4-bit cell value;
  - MINE_CODE constant;
  - the FSM state enum;
  - the offset tables (dx/dy per k, as signed 2-bit constants).
- Sub-module neighbour_addr_gen (combinational): takes coordinate, dim and k; returns the neighbour address and an in-range flag.
- The FSM, accumulator and write logic stay in the top module.

Test Plan:
- dim=3, mines at (1,1) and (2,1), accept (1,0):
  - reads at cycles 1..9, with 6 rd_en pulses (row y=-1 skipped);
  - write at cycle 11 with val=2.
- dim=3, mine at (0,0), accept (0,0):
  - 4 in-range reads; write val=15; board_done stays 0.
- dim=2, mines at all 8 neighbours of (1,1), (1,1) itself clear, accept (1,1) -> val=8, no overflow.
- dim=3, accept (3,3) with no mines -> write val=0; board_done rises at E0+12. Then accept (0,0) -> board_done clears.
- dim=3, accept (5,2) -> coord_err pulse at E0+1, no mine_rd_en, no cnt_wr_en, coord_ready high at E0+2.
- Assert rst at E0+5 mid-READ -> no write; all outputs at reset values the next cycle; a fresh accept then completes normally.
